// File: rtl/four_and_resp_checker.sv
// Response checker for the four-input AND block: compares sampled a/b/c/d/e/f/g
// against e=a&b, f=c&d, g=a&b&c&d, tracks coverage and errors, and issues a verdict.
module four_and_resp_checker #(
  parameter int N_SAMPLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      cov_mask,
  output logic [6:0]       first_err_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             first_err_seen;
  logic [3:0]       vec;
  logic             mismatch;
  logic             last;
  logic [CNT_W-1:0] smp_cnt_next;
  logic [CNT_W-1:0] err_cnt_next;
  logic [15:0]      cov_mask_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic ref_mismatch(input logic [3:0] v, input logic [2:0] resp);
    return resp != {v[3] & v[2], v[1] & v[0], &v};
  endfunction

  // Post-update values of the sample being accepted; pass is judged on these.
  always_comb begin
    vec           = {a, b, c, d};
    mismatch      = ref_mismatch(vec, {e, f, g});
    smp_cnt_next  = smp_cnt + 1'b1;
    err_cnt_next  = mismatch ? sat_inc(err_cnt) : err_cnt;
    cov_mask_next = cov_mask | (16'd1 << vec);
    last          = (smp_cnt_next == CNT_W'(N_SAMPLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      smp_cnt        <= '0;
      err_cnt        <= '0;
      cov_mask       <= 16'h0000;
      first_err_vec  <= 7'd0;
      first_err_seen <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            smp_cnt        <= '0;
            err_cnt        <= '0;
            cov_mask       <= 16'h0000;
            first_err_vec  <= 7'd0;
            first_err_seen <= 1'b0;
          end
        end
        RUN: begin
          if (smp_valid) begin
            smp_cnt  <= smp_cnt_next;
            err_cnt  <= err_cnt_next;
            cov_mask <= cov_mask_next;
            if (mismatch && !first_err_seen) begin
              first_err_vec  <= {a, b, c, d, e, f, g};
              first_err_seen <= 1'b1;
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt_next == '0) && (cov_mask_next == 16'hFFFF);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_and_resp_checker.sv
// Bench for four_and_resp_checker: three parameterisations driven in parallel,
// checked every cycle against a rule-level model plus literal spot checks.
module tb_four_and_resp_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic smp_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic e = 1'b0, f = 1'b0, g = 1'b0;

  always #5 clk = ~clk;

  logic       busy0, done0, pass0;
  logic [7:0] smp0, err0;
  logic [15:0] cov0;
  logic [6:0] fev0;
  logic       busy1, done1, pass1;
  logic [4:0] smp1, err1;
  logic [15:0] cov1;
  logic [6:0] fev1;
  logic       busy2, done2, pass2;
  logic [3:0] smp2, err2;
  logic [15:0] cov2;
  logic [6:0] fev2;

  four_and_resp_checker #(.N_SAMPLES(16), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .busy(busy0), .done(done0), .pass(pass0), .smp_cnt(smp0), .err_cnt(err0),
    .cov_mask(cov0), .first_err_vec(fev0));

  four_and_resp_checker #(.N_SAMPLES(31), .CNT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .busy(busy1), .done(done1), .pass(pass1), .smp_cnt(smp1), .err_cnt(err1),
    .cov_mask(cov1), .first_err_vec(fev1));

  four_and_resp_checker #(.N_SAMPLES(15), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .busy(busy2), .done(done2), .pass(pass2), .smp_cnt(smp2), .err_cnt(err2),
    .cov_mask(cov2), .first_err_vec(fev2));

  logic        o_busy [3];
  logic        o_done [3];
  logic        o_pass [3];
  logic [7:0]  o_smp  [3];
  logic [7:0]  o_err  [3];
  logic [15:0] o_cov  [3];
  logic [6:0]  o_fev  [3];

  always_comb begin
    o_busy[0] = busy0; o_done[0] = done0; o_pass[0] = pass0;
    o_smp[0] = smp0; o_err[0] = err0; o_cov[0] = cov0; o_fev[0] = fev0;
    o_busy[1] = busy1; o_done[1] = done1; o_pass[1] = pass1;
    o_smp[1] = {3'b000, smp1}; o_err[1] = {3'b000, err1}; o_cov[1] = cov1; o_fev[1] = fev1;
    o_busy[2] = busy2; o_done[2] = done2; o_pass[2] = pass2;
    o_smp[2] = {4'b0000, smp2}; o_err[2] = {4'b0000, err2}; o_cov[2] = cov2; o_fev[2] = fev2;
  end

  // Model: run length and error ceiling per instance, integer bookkeeping.
  localparam int NS   [3] = '{16, 31, 15};
  localparam int EMAX [3] = '{255, 31, 15};

  logic        in_bad;
  logic [3:0]  in_vec;
  assign in_vec = {a, b, c, d};
  assign in_bad = (e != (a & b)) || (f != (c & d)) || (g != (a & b & c & d));

  bit          m_busy [3], m_done [3], m_pass [3], m_seen [3];
  int          m_smp  [3], m_err  [3];
  logic [15:0] m_cov  [3];
  logic [6:0]  m_fev  [3];
  bit          nx_busy [3], nx_done [3], nx_pass [3], nx_seen [3];
  int          nx_smp  [3], nx_err  [3];
  logic [15:0] nx_cov  [3];
  logic [6:0]  nx_fev  [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nx_busy[i] = m_busy[i]; nx_done[i] = m_done[i]; nx_pass[i] = m_pass[i];
      nx_seen[i] = m_seen[i]; nx_smp[i] = m_smp[i]; nx_err[i] = m_err[i];
      nx_cov[i] = m_cov[i]; nx_fev[i] = m_fev[i];
      if (!m_busy[i]) begin
        if (start) begin
          nx_busy[i] = 1'b1; nx_done[i] = 1'b0; nx_pass[i] = 1'b0; nx_seen[i] = 1'b0;
          nx_smp[i] = 0; nx_err[i] = 0; nx_cov[i] = 16'h0000; nx_fev[i] = 7'd0;
        end
      end else if (smp_valid) begin
        nx_smp[i] = m_smp[i] + 1;
        nx_cov[i][in_vec] = 1'b1;
        if (in_bad) begin
          nx_err[i] = (m_err[i] < EMAX[i]) ? m_err[i] + 1 : m_err[i];
          if (!m_seen[i]) begin
            nx_fev[i] = {a, b, c, d, e, f, g};
            nx_seen[i] = 1'b1;
          end
        end
        if (nx_smp[i] == NS[i]) begin
          nx_busy[i] = 1'b0;
          nx_done[i] = 1'b1;
          nx_pass[i] = (nx_err[i] == 0) && (nx_cov[i] == 16'hFFFF);
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_pass[i] <= 1'b0; m_seen[i] <= 1'b0;
        m_smp[i] <= 0; m_err[i] <= 0; m_cov[i] <= 16'h0000; m_fev[i] <= 7'd0;
      end else begin
        m_busy[i] <= nx_busy[i]; m_done[i] <= nx_done[i]; m_pass[i] <= nx_pass[i];
        m_seen[i] <= nx_seen[i]; m_smp[i] <= nx_smp[i]; m_err[i] <= nx_err[i];
        m_cov[i] <= nx_cov[i]; m_fev[i] <= nx_fev[i];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input int idx, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: actual 0x%0h required 0x%0h", nm, idx, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check("busy", i, o_busy[i], m_busy[i]);
        check("done", i, o_done[i], m_done[i]);
        if (m_done[i]) check("pass", i, o_pass[i], m_pass[i]);
        check("smp_cnt", i, o_smp[i], m_smp[i]);
        check("err_cnt", i, o_err[i], m_err[i]);
        check("cov_mask", i, o_cov[i], m_cov[i]);
        check("first_err_vec", i, o_fev[i], m_fev[i]);
      end
    end
  end

  // One clock of stimulus; flip inverts {e,f,g} relative to the correct response.
  task automatic cyc(input logic st, input logic vl, input logic [3:0] v, input logic [2:0] flip);
    start = st;
    smp_valid = vl;
    {a, b, c, d} = v;
    e = (v[3] & v[2]) ^ flip[2];
    f = (v[1] & v[0]) ^ flip[1];
    g = (&v) ^ flip[0];
    @(posedge clk);
    #1;
    start = 1'b0;
    smp_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_on = 1'b1;
    check("rst_done", 0, done0, 0);
    check("rst_smp", 0, smp0, 0);

    // Good run: 0..15 all correct.
    cyc(1'b1, 1'b0, 4'd0, 3'b000);
    check("start_busy", 0, busy0, 1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 3'b000);
    check("good_done", 0, done0, 1);
    check("good_busy", 0, busy0, 0);
    check("good_pass", 0, pass0, 1);
    check("good_err", 0, err0, 0);
    check("good_smp", 0, smp0, 16);
    check("good_cov", 0, cov0, 16'hFFFF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd3, 3'b111);
    check("hold_smp", 0, smp0, 16);
    check("hold_pass", 0, pass0, 1);

    // Restart from DONE, single fault: g=0 at 1111.
    cyc(1'b1, 1'b0, 4'd0, 3'b000);
    check("restart_smp", 0, smp0, 0);
    check("restart_done", 0, done0, 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), (i == 15) ? 3'b001 : 3'b000);
    check("fault_err", 0, err0, 1);
    check("fault_fev", 0, fev0, 7'b1111110);
    check("fault_pass", 0, pass0, 0);
    check("fault_done", 0, done0, 1);

    // Coverage hole with start+valid on the start edge and a mid-run start pulse.
    cyc(1'b1, 1'b1, 4'd5, 3'b000);
    check("startvalid_smp", 0, smp0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'd0, 3'b000);
    cyc(1'b1, 1'b1, 4'd0, 3'b000);
    check("midstart_smp", 0, smp0, 6);
    check("midstart_busy", 0, busy0, 1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 4'd0, 3'b000);
    check("hole_err", 0, err0, 0);
    check("hole_cov", 0, cov0, 16'h0001);
    check("hole_pass", 0, pass0, 0);
    check("hole_smp", 0, smp0, 16);

    // Asynchronous reset mid-run after 5 samples.
    cyc(1'b1, 1'b0, 4'd0, 3'b000);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'(i + 10), 3'b010);
    check("pre_rst_smp", 0, smp0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 0, busy0, 0);
    check("arst_smp", 0, smp0, 0);
    check("arst_err", 0, err0, 0);
    check("arst_cov", 0, cov0, 0);
    check("arst_fev", 0, fev0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'(i), 3'b000);
    check("idle_smp", 0, smp0, 0);
    check("idle_busy", 0, busy0, 0);

    // Saturation: e inverted on every sample.
    cyc(1'b1, 1'b0, 4'd0, 3'b000);
    for (int i = 0; i < 31; i++) cyc(1'b0, 1'b1, 4'(i % 16), 3'b100);
    check("sat5_err", 1, err1, 31);
    check("sat5_smp", 1, smp1, 31);
    check("sat5_done", 1, done1, 1);
    check("sat5_pass", 1, pass1, 0);
    check("sat4_err", 2, err2, 15);
    check("sat4_done", 2, done2, 1);
    check("sat8_err", 0, err0, 16);
    check("sat8_fev", 0, fev0, 7'b0000100);
    cyc(1'b0, 1'b0, 4'd0, 3'b000);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/four_and_resp_checker.md
# four_and_resp_checker

Synthesizable response checker for the four-input AND block: the receiving end of the toggling a/b/c/d stimulus stream. It samples the stimulus vector and the block's e/f/g outputs on a valid strobe and compares them against the reference function. It counts mismatches, records which of the 16 input combinations were exercised, and reports a registered pass/fail verdict after a fixed number of samples. It sits beside the AND block on the board or in a bench, replacing hand inspection of waveforms.

## Interface
- N_SAMPLES, 16: samples per run; legal range 1 .. 2^CNT_W-1
- CNT_W, 8: width of the sample and error counters
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a run
- smp_valid  in  1  a/b/c/d/e/f/g are valid this cycle
- a, b, c, d  in  1 each  stimulus applied to the AND block
- e, f, g  in  1 each  AND block responses
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  verdict; meaningful only while done=1
- smp_cnt  out  CNT_W  samples accepted this run
- err_cnt  out  CNT_W  mismatching samples; saturates at all-ones
- cov_mask  out  16  bit {a,b,c,d} (a = MSB of index) set when that combination is sampled
- first_err_vec  out  7  {a,b,c,d,e,f,g} captured at the first mismatch of the run

## Operation
- Reference function: e_exp = a&b, f_exp = c&d, g_exp = a&b&c&d. A mismatch is any of e/f/g differing from its expected value.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN. On the same edge, clear smp_cnt, err_cnt, cov_mask, first_err_vec, pass and the internal first-error flag.
  - smp_valid is ignored.
- RUN, on each cycle with smp_valid=1:
  - smp_cnt += 1
  - set cov_mask[{a,b,c,d}]
  - on a mismatch: err_cnt += 1, held at 2^CNT_W-1 once it reaches that value
  - on the first mismatch of the run only: load first_err_vec
- RUN exit: when the accepted sample makes smp_cnt equal N_SAMPLES, go to DONE on that same edge.
  - pass is loaded from the post-update values: pass = (err_cnt_next == 0) && (cov_mask_next == 16'hFFFF).
- start during RUN is ignored; a run cannot be restarted without first reaching DONE or applying reset.
- DONE:
  - All results hold. smp_valid is ignored.
  - start=1 → RUN with the same clear as from IDLE.
- Reset (rst_n=0, at any time including mid-run): state = IDLE; busy, done, pass = 0; smp_cnt, err_cnt, first_err_vec = 0; cov_mask = 16'h0000. Any partial run is discarded.
- Coverage requirement: pass needs all 16 combinations. With N_SAMPLES < 16, pass is therefore always 0; this is intended.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Sample accepted at edge k: smp_cnt, err_cnt, cov_mask and first_err_vec show its effect after edge k.
- Final sample accepted at edge k: done=1, busy=0 and pass are valid after edge k (zero extra latency).
- start sampled at edge k from IDLE/DONE: busy=1 after edge k. A smp_valid in that same cycle is not counted; the first countable sample is at edge k+1.
- Back-to-back smp_valid every cycle is supported; throughput is one sample per clock.
- Result hold: done stays high until start or reset.

## Test plan
- Reset and idle behaviour:
  - Assert rst_n=0 mid-run after 5 samples → all outputs 0 and cov_mask = 0 immediately, without waiting for a clock edge.
  - After release, smp_valid pulses in IDLE → smp_cnt stays 0.
- Good run: start, then 16 valid samples counting {a,b,c,d} from 0 to 15 with correct e/f/g →
  - done=1 on the cycle after the 16th sample
  - pass=1, err_cnt=0, smp_cnt=16, cov_mask=16'hFFFF
- Single fault: same sequence with g forced to 0 at {a,b,c,d}=4'b1111 → err_cnt=1, first_err_vec=7'b1111110, pass=0.
- Coverage hole: 16 correct samples, all with {a,b,c,d}=4'b0000 → err_cnt=0, cov_mask=16'h0001, pass=0.
- Saturation with CNT_W=5, N_SAMPLES=31:
  - 31 samples with e inverted → err_cnt=31 with no wrap, pass=0.
  - Repeat with CNT_W=4, N_SAMPLES=15, which must also stop at 15.
- Control corners:
  - start pulsed mid-RUN → ignored; counts continue.
  - start in DONE → counters clear and a new run completes correctly.
  - start and smp_valid in the same cycle → that sample is not counted.
